// File: rtl/msrv32_target_adder_pipe_pkg.sv
// ----------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the msrv32 target-address unit:
//   mode_t  - operation mode encoding carried on mode_in
//   PC_INC  - link-address increment (size of one 32-bit instruction)
// ----------------------------------------------------------------------------
package msrv32_pkg;

   typedef enum logic [1:0] {
      MODE_AUIPC  = 2'b00,
      MODE_JAL    = 2'b01,
      MODE_JALR   = 2'b10,
      MODE_BRANCH = 2'b11
   } mode_t;

   localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/msrv32_target_adder_pipe_if.sv
// ----------------------------------------------------------------------------
// msrv32_target_adder_pipe_if
// Request/response bundle of the target-address unit.
//   master : issues requests (flush, req_valid, mode, pc, rs_1, imm) and
//            accepts results (rsp_ready)
//   slave  : the target-address unit itself
// ----------------------------------------------------------------------------
interface msrv32_target_adder_pipe_if #(
   parameter int XLEN = 32
);

   logic            flush;
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      mode;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] rs_1;
   logic [XLEN-1:0] imm;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] iadder;
   logic [XLEN-1:0] link;
   logic            misaligned;

   modport master (
      output flush, req_valid, mode, pc, rs_1, imm, rsp_ready,
      input  req_ready, rsp_valid, iadder, link, misaligned
   );

   modport slave (
      input  flush, req_valid, mode, pc, rs_1, imm, rsp_ready,
      output req_ready, rsp_valid, iadder, link, misaligned
   );

endinterface

// File: rtl/msrv32_target_adder_pipe_tap_stage.sv
// ----------------------------------------------------------------------------
// msrv32_tap_stage
// One elastic pipeline register: a valid bit plus a WIDTH-bit payload.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid and data)
//   flush      : clear valid on the next edge and refuse new data
//   load       : stage is free to take valid_d/data_d this cycle
//   valid_d    : incoming valid
//   data_d     : incoming payload
//   valid_q    : stage holds a live entry
//   data_q     : held payload
// ----------------------------------------------------------------------------
module msrv32_tap_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic             valid_d,
   input  logic [WIDTH-1:0] data_d,
   output logic             valid_q,
   output logic [WIDTH-1:0] data_q
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         // NOTE: the payload is reset too, because the unit's outputs must
         // read zero while in reset; it is never cleared by flush.
         data_q  <= '0;
      end else begin
         if (flush) begin
            valid_q <= 1'b0;
         end else if (load) begin
            valid_q <= valid_d;
         end
         // Payload only moves for a real entry, so held outputs stay stable
         // and bubbles do not toggle the data path.
         if (load && valid_d && !flush) begin
            data_q <= data_d;
         end
      end
   end

endmodule

// File: rtl/msrv32_target_adder_pipe.sv
// ----------------------------------------------------------------------------
// msrv32_target_adder_pipe
// Pipelined branch/jump/AUIPC target adder with link-address generation.
//   ms_riscv32_mp_clk_in   : clock
//   ms_riscv32_mp_rst_n_in : asynchronous active-low reset
//   flush_in               : kill all in-flight entries, block the current input
//   valid_in / ready_out   : request handshake
//   mode_in, pc_in, rs_1_in, imm_in : request operands
//   valid_out / ready_in   : result handshake
//   iadder_out, link_out, misaligned_out : result
// STAGES=1 computes everything at the input; STAGES=2 splits the add at the
// half-word boundary and finishes in the second stage.
// ----------------------------------------------------------------------------
module msrv32_target_adder_pipe
   import msrv32_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 1,
   parameter int IALIGN = 32
) (
   input  logic            ms_riscv32_mp_clk_in,
   input  logic            ms_riscv32_mp_rst_n_in,
   input  logic            flush_in,
   input  logic            valid_in,
   output logic            ready_out,
   input  logic [1:0]      mode_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rs_1_in,
   input  logic [XLEN-1:0] imm_in,
   output logic            valid_out,
   input  logic            ready_in,
   output logic [XLEN-1:0] iadder_out,
   output logic [XLEN-1:0] link_out,
   output logic            misaligned_out
);

   localparam int HALF = XLEN / 2;

   typedef struct packed {
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] link;
      logic            misaligned;
   } result_t;

   // Intermediate state of the split adder between stage 1 and stage 2.
   typedef struct packed {
      logic            carry;
      logic [HALF-1:0] sum_lo;
      logic [HALF-1:0] base_hi;
      logic [HALF-1:0] imm_hi;
      mode_t           mode;
      logic [XLEN-1:0] pc;
   } split_t;

   // JALR clears bit 0 before the alignment check; AUIPC is data, not a
   // control-flow target, so it never flags.
   function automatic result_t finalize(input mode_t mode,
                                        input logic [XLEN-1:0] sum,
                                        input logic [XLEN-1:0] pc);
      result_t r;
      r.target = sum;
      if (mode == MODE_JALR) r.target[0] = 1'b0;
      r.misaligned = (IALIGN == 32) && (mode != MODE_AUIPC) && r.target[1];
      r.link       = pc + XLEN'(PC_INC);
      return r;
   endfunction

   mode_t           mode;
   logic [XLEN-1:0] base;
   result_t         out_q;

   assign mode = mode_t'(mode_in);
   assign base = (mode == MODE_JALR) ? rs_1_in : pc_in;

   assign iadder_out     = out_q.target;
   assign link_out       = out_q.link;
   assign misaligned_out = out_q.misaligned;

   if (STAGES == 1) begin : g_one
      logic    load;
      result_t res_d;

      assign load      = !valid_out || ready_in;
      assign ready_out = load;
      assign res_d     = finalize(mode, base + imm_in, pc_in);

      msrv32_tap_stage #(.WIDTH($bits(result_t))) u_stage_1 (
         .clk     (ms_riscv32_mp_clk_in),
         .rst_n   (ms_riscv32_mp_rst_n_in),
         .flush   (flush_in),
         .load    (load),
         .valid_d (valid_in),
         .data_d  (res_d),
         .valid_q (valid_out),
         .data_q  (out_q)
      );
   end else if (STAGES == 2) begin : g_two
      logic          load_1;
      logic          load_2;
      logic          valid_1;
      logic [HALF:0] lo_sum;
      split_t        split_d;
      split_t        split_q;
      logic [HALF-1:0] hi_sum;
      result_t       res_d;

      // Stage 1 may load when it is empty or its entry advances into stage 2.
      assign load_2    = !valid_out || ready_in;
      assign load_1    = !valid_1 || load_2;
      assign ready_out = load_1;

      assign lo_sum = {1'b0, base[HALF-1:0]} + {1'b0, imm_in[HALF-1:0]};

      assign split_d.carry   = lo_sum[HALF];
      assign split_d.sum_lo  = lo_sum[HALF-1:0];
      assign split_d.base_hi = base[XLEN-1:HALF];
      assign split_d.imm_hi  = imm_in[XLEN-1:HALF];
      assign split_d.mode    = mode;
      assign split_d.pc      = pc_in;

      msrv32_tap_stage #(.WIDTH($bits(split_t))) u_stage_1 (
         .clk     (ms_riscv32_mp_clk_in),
         .rst_n   (ms_riscv32_mp_rst_n_in),
         .flush   (flush_in),
         .load    (load_1),
         .valid_d (valid_in),
         .data_d  (split_d),
         .valid_q (valid_1),
         .data_q  (split_q)
      );

      assign hi_sum = split_q.base_hi + split_q.imm_hi
                    + {{(HALF-1){1'b0}}, split_q.carry};
      assign res_d  = finalize(split_q.mode, {hi_sum, split_q.sum_lo}, split_q.pc);

      msrv32_tap_stage #(.WIDTH($bits(result_t))) u_stage_2 (
         .clk     (ms_riscv32_mp_clk_in),
         .rst_n   (ms_riscv32_mp_rst_n_in),
         .flush   (flush_in),
         .load    (load_2),
         .valid_d (valid_1),
         .data_d  (res_d),
         .valid_q (valid_out),
         .data_q  (out_q)
      );
   end else begin : g_bad
      $error("msrv32_target_adder_pipe: STAGES must be 1 or 2");
   end

endmodule

// File: tb/tb_msrv32_target_adder_pipe.sv
// ----------------------------------------------------------------------------
// tb_msrv32_target_adder_pipe
// Three instances share one request stream:
//   dut_a : STAGES=1, IALIGN=32
//   dut_b : STAGES=2, IALIGN=32
//   dut_c : STAGES=1, IALIGN=16
// Directed vectors with hand-computed results, then hand-written sequences
// for back-pressure, flush and reset mid-stream.
// ----------------------------------------------------------------------------
module tb_msrv32_target_adder_pipe;
   import msrv32_pkg::*;

   logic clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   msrv32_target_adder_pipe_if #(.XLEN(32)) if_a ();
   msrv32_target_adder_pipe_if #(.XLEN(32)) if_b ();
   msrv32_target_adder_pipe_if #(.XLEN(32)) if_c ();

   msrv32_target_adder_pipe #(.XLEN(32), .STAGES(1), .IALIGN(32)) dut_a (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_n_in (rst_n),
      .flush_in               (if_a.flush),
      .valid_in               (if_a.req_valid),
      .ready_out              (if_a.req_ready),
      .mode_in                (if_a.mode),
      .pc_in                  (if_a.pc),
      .rs_1_in                (if_a.rs_1),
      .imm_in                 (if_a.imm),
      .valid_out              (if_a.rsp_valid),
      .ready_in               (if_a.rsp_ready),
      .iadder_out             (if_a.iadder),
      .link_out               (if_a.link),
      .misaligned_out         (if_a.misaligned)
   );

   msrv32_target_adder_pipe #(.XLEN(32), .STAGES(2), .IALIGN(32)) dut_b (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_n_in (rst_n),
      .flush_in               (if_b.flush),
      .valid_in               (if_b.req_valid),
      .ready_out              (if_b.req_ready),
      .mode_in                (if_b.mode),
      .pc_in                  (if_b.pc),
      .rs_1_in                (if_b.rs_1),
      .imm_in                 (if_b.imm),
      .valid_out              (if_b.rsp_valid),
      .ready_in               (if_b.rsp_ready),
      .iadder_out             (if_b.iadder),
      .link_out               (if_b.link),
      .misaligned_out         (if_b.misaligned)
   );

   msrv32_target_adder_pipe #(.XLEN(32), .STAGES(1), .IALIGN(16)) dut_c (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_n_in (rst_n),
      .flush_in               (if_c.flush),
      .valid_in               (if_c.req_valid),
      .ready_out              (if_c.req_ready),
      .mode_in                (if_c.mode),
      .pc_in                  (if_c.pc),
      .rs_1_in                (if_c.rs_1),
      .imm_in                 (if_c.imm),
      .valid_out              (if_c.rsp_valid),
      .ready_in               (if_c.rsp_ready),
      .iadder_out             (if_c.iadder),
      .link_out               (if_c.link),
      .misaligned_out         (if_c.misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      mode_t       mode;
      logic [31:0] pc;
      logic [31:0] rs_1;
      logic [31:0] imm;
      logic [31:0] exp_target;
      logic [31:0] exp_link;
      logic        exp_mis;   // expectation for IALIGN=32
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input mode_t m, input logic [31:0] p,
                      input logic [31:0] r, input logic [31:0] i);
      if_a.req_valid = v; if_b.req_valid = v; if_c.req_valid = v;
      if_a.mode = m;      if_b.mode = m;      if_c.mode = m;
      if_a.pc = p;        if_b.pc = p;        if_c.pc = p;
      if_a.rs_1 = r;      if_b.rs_1 = r;      if_c.rs_1 = r;
      if_a.imm = i;       if_b.imm = i;       if_c.imm = i;
   endtask

   task automatic set_ready(input logic r);
      if_a.rsp_ready = r; if_b.rsp_ready = r; if_c.rsp_ready = r;
   endtask

   task automatic set_flush(input logic f);
      if_a.flush = f; if_b.flush = f; if_c.flush = f;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      put(1'b0, MODE_AUIPC, 32'h0, 32'h0, 32'h0);
      set_flush(1'b0);
      set_ready(1'b1);
      #3;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Back-pressure request k: BRANCH at pc 0x1000+0x10k, imm 0x22.
   function automatic logic [31:0] bp_pc(input int k);
      return 32'h0000_1000 + 32'(k) * 32'h10;
   endfunction

   initial begin
      int in_idx;
      logic acc;

      vecs[0] = '{MODE_JAL,    32'h0000_1000, 32'hDEAD_0000, 32'h0000_0010, 32'h0000_1010, 32'h0000_1004, 1'b0};
      vecs[1] = '{MODE_JALR,   32'h0000_0100, 32'h0000_2003, 32'h0000_0000, 32'h0000_2002, 32'h0000_0104, 1'b1};
      vecs[2] = '{MODE_AUIPC,  32'h0000_FFFF, 32'hDEAD_0000, 32'h0000_0001, 32'h0001_0000, 32'h0001_0003, 1'b0};
      vecs[3] = '{MODE_AUIPC,  32'hFFFF_FFFC, 32'hDEAD_0000, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[4] = '{MODE_BRANCH, 32'h0000_0400, 32'hDEAD_0000, 32'hFFFF_FFFE, 32'h0000_03FE, 32'h0000_0404, 1'b1};
      vecs[5] = '{MODE_AUIPC,  32'h0000_0002, 32'hDEAD_0000, 32'h0000_0000, 32'h0000_0002, 32'h0000_0006, 1'b0};
      vecs[6] = '{MODE_JALR,   32'h8000_0000, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 32'h8000_0004, 1'b0};
      vecs[7] = '{MODE_JAL,    32'h7FFF_FFF0, 32'hDEAD_0000, 32'h0000_0012, 32'h8000_0002, 32'h7FFF_FFF4, 1'b1};
      vecs[8] = '{MODE_JALR,   32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0004, 1'b0};
      vecs[9] = '{MODE_BRANCH, 32'hFFFF_0000, 32'hDEAD_0000, 32'h0001_0004, 32'h0000_0004, 32'hFFFF_0004, 1'b0};

      // ---- reset state ----
      rst_n = 1'b0;
      put(1'b0, MODE_AUIPC, 32'h0, 32'h0, 32'h0);
      set_flush(1'b0);
      set_ready(1'b1);
      #1;
      check("rst_a_valid",  32'(if_a.rsp_valid),  32'h0);
      check("rst_a_iadder", if_a.iadder,          32'h0);
      check("rst_a_link",   if_a.link,            32'h0);
      check("rst_a_mis",    32'(if_a.misaligned), 32'h0);
      check("rst_b_valid",  32'(if_b.rsp_valid),  32'h0);
      check("rst_b_iadder", if_b.iadder,          32'h0);
      do_reset();
      check("rst_a_ready", 32'(if_a.req_ready), 32'h1);
      check("rst_b_ready", 32'(if_b.req_ready), 32'h1);

      // ---- directed vectors, ready_in held at 1 ----
      for (int i = 0; i < 10; i++) begin
         put(1'b1, vecs[i].mode, vecs[i].pc, vecs[i].rs_1, vecs[i].imm);
         tick();
         put(1'b0, MODE_AUIPC, 32'h0, 32'h0, 32'h0);
         check($sformatf("v%0d_a_valid", i),  32'(if_a.rsp_valid),  32'h1);
         check($sformatf("v%0d_a_iadder", i), if_a.iadder,          vecs[i].exp_target);
         check($sformatf("v%0d_a_link", i),   if_a.link,            vecs[i].exp_link);
         check($sformatf("v%0d_a_mis", i),    32'(if_a.misaligned), 32'(vecs[i].exp_mis));
         check($sformatf("v%0d_c_iadder", i), if_c.iadder,          vecs[i].exp_target);
         check($sformatf("v%0d_c_mis", i),    32'(if_c.misaligned), 32'h0);
         check($sformatf("v%0d_b_early", i),  32'(if_b.rsp_valid),  32'h0);
         tick();
         check($sformatf("v%0d_b_valid", i),  32'(if_b.rsp_valid),  32'h1);
         check($sformatf("v%0d_b_iadder", i), if_b.iadder,          vecs[i].exp_target);
         check($sformatf("v%0d_b_link", i),   if_b.link,            vecs[i].exp_link);
         check($sformatf("v%0d_b_mis", i),    32'(if_b.misaligned), 32'(vecs[i].exp_mis));
         check($sformatf("v%0d_a_drain", i),  32'(if_a.rsp_valid),  32'h0);
      end

      // ---- back-pressure on the two-stage instance ----
      do_reset();
      set_ready(1'b0);
      in_idx = 0;
      put(1'b1, MODE_BRANCH, bp_pc(0), 32'hDEAD_0000, 32'h22);
      check("bp_ready_0", 32'(if_b.req_ready), 32'h1);
      tick();
      in_idx = 1;
      put(1'b1, MODE_BRANCH, bp_pc(1), 32'hDEAD_0000, 32'h22);
      check("bp_ready_1", 32'(if_b.req_ready), 32'h1);
      tick();
      in_idx = 2;
      put(1'b1, MODE_BRANCH, bp_pc(2), 32'hDEAD_0000, 32'h22);
      for (int s = 0; s < 3; s++) begin
         check($sformatf("bp_full_ready_%0d", s), 32'(if_b.req_ready),  32'h0);
         check($sformatf("bp_hold_valid_%0d", s), 32'(if_b.rsp_valid),  32'h1);
         check($sformatf("bp_hold_iadder_%0d", s), if_b.iadder,         bp_pc(0) + 32'h22);
         check($sformatf("bp_hold_link_%0d", s),   if_b.link,           bp_pc(0) + 32'h4);
         check($sformatf("bp_hold_mis_%0d", s),   32'(if_b.misaligned), 32'h1);
         if (s < 2) tick();
      end
      set_ready(1'b1);
      #1;
      check("bp_release_ready", 32'(if_b.req_ready), 32'h1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("bp_out%0d_valid", k),  32'(if_b.rsp_valid), 32'h1);
         check($sformatf("bp_out%0d_iadder", k), if_b.iadder,         bp_pc(k) + 32'h22);
         check($sformatf("bp_out%0d_link", k),   if_b.link,           bp_pc(k) + 32'h4);
         acc = if_b.req_valid && if_b.req_ready;
         tick();
         if (acc) in_idx++;
         if (in_idx < 4) put(1'b1, MODE_BRANCH, bp_pc(in_idx), 32'hDEAD_0000, 32'h22);
         else            put(1'b0, MODE_AUIPC, 32'h0, 32'h0, 32'h0);
      end
      check("bp_accepted", 32'(in_idx), 32'd4);
      check("bp_no_dup",   32'(if_b.rsp_valid), 32'h0);

      // ---- flush with the two-stage pipeline full and valid_in=1 ----
      do_reset();
      set_ready(1'b0);
      put(1'b1, MODE_JAL, 32'h0000_2000, 32'h0, 32'h8);
      tick();
      put(1'b1, MODE_JAL, 32'h0000_3000, 32'h0, 32'h8);
      tick();
      check("fl_full", 32'(if_b.rsp_valid), 32'h1);
      put(1'b1, MODE_JAL, 32'h0000_4000, 32'h0, 32'h8);
      set_flush(1'b1);
      tick();
      set_flush(1'b0);
      put(1'b0, MODE_AUIPC, 32'h0, 32'h0, 32'h0);
      check("fl_b_valid", 32'(if_b.rsp_valid), 32'h0);
      check("fl_a_valid", 32'(if_a.rsp_valid), 32'h0);
      check("fl_b_ready", 32'(if_b.req_ready), 32'h1);
      set_ready(1'b1);
      tick();
      check("fl_b_empty_1", 32'(if_b.rsp_valid), 32'h0);
      tick();
      check("fl_b_empty_2", 32'(if_b.rsp_valid), 32'h0);

      // ---- reset mid-stream ----
      do_reset();
      put(1'b1, MODE_AUIPC, 32'h0000_0100, 32'h0, 32'h4);
      tick();
      put(1'b1, MODE_AUIPC, 32'h0000_0200, 32'h0, 32'h4);
      tick();
      put(1'b0, MODE_AUIPC, 32'h0, 32'h0, 32'h0);
      check("mr_pre_valid", 32'(if_b.rsp_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_b_valid",  32'(if_b.rsp_valid),  32'h0);
      check("mr_b_iadder", if_b.iadder,          32'h0);
      check("mr_b_link",   if_b.link,            32'h0);
      check("mr_b_mis",    32'(if_b.misaligned), 32'h0);
      check("mr_a_valid",  32'(if_a.rsp_valid),  32'h0);
      #1;
      rst_n = 1'b1;
      #1;
      check("mr_ready", 32'(if_b.req_ready), 32'h1);
      tick();
      put(1'b1, MODE_AUIPC, 32'h0000_0010, 32'h0, 32'h20);
      tick();
      put(1'b0, MODE_AUIPC, 32'h0, 32'h0, 32'h0);
      check("mr_lat_1", 32'(if_b.rsp_valid), 32'h0);
      tick();
      check("mr_lat_2",  32'(if_b.rsp_valid), 32'h1);
      check("mr_iadder", if_b.iadder,         32'h0000_0030);
      check("mr_link",   if_b.link,           32'h0000_0014);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
